// File: rtl/float_pack.sv
// Shared definitions for the reduced-float arithmetic units: op codes, bias
// and the saturated maximum magnitude.
package float_pack;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_RSV = 2'b11
  } op_code_e;

  function automatic int float_bias(input int n_exp);
    return (1 << (n_exp - 1)) - 1;
  endfunction

  // Largest representable magnitude: exponent 2^n_exp-2, mantissa all ones.
  function automatic logic [31:0] float_sat_max(input int n_exp, input int n_man);
    logic [31:0] e_max;
    e_max = (32'(1) << n_exp) - 32'd2;
    return (e_max << n_man) | ((32'(1) << n_man) - 32'd1);
  endfunction

endpackage

// File: rtl/float_unit_seq_if.sv
// Request/response channels of the sequential float unit.
interface float_unit_seq_if
  import float_pack::*;
#(
  parameter int N_exposant = 8,
  parameter int N_mantisse = 23
) ();
  localparam int W = 1 + N_exposant + N_mantisse;

  // A transfer happens on a rising clk edge where valid && ready are both high;
  // the producer keeps its payload stable while valid is high and ready is low.
  logic           op_valid;
  logic           op_ready;
  op_code_e       op_code;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res;
  logic           ovf;
  logic           unf;

  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input  op_ready, res_valid, res, ovf, unf
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, res, ovf, unf
  );
endinterface

// File: rtl/float_normalize.sv
// Combinational leading-one detect, normalise shift, saturate/underflow and pack.
// mag has its unit bit at position 2*N_mantisse; exp_in is the biased exponent there.
module float_normalize
  import float_pack::*;
#(
  parameter int N_exposant = 8,
  parameter int N_mantisse = 23
) (
  input  logic                             sign,
  input  logic signed [N_exposant+1:0]     exp_in,
  input  logic [2*N_mantisse+1:0]          mag,
  input  logic                             force_zero,
  output logic [N_exposant+N_mantisse:0]   res,
  output logic                             ovf,
  output logic                             unf
);
  localparam int E    = N_exposant;
  localparam int M    = N_mantisse;
  localparam int W    = 1 + E + M;
  localparam int P    = 2 * M + 2;
  localparam int EMAX = (1 << E) - 2;
  localparam logic [31:0] SAT_FULL = float_sat_max(E, M);

  int           lead;
  int           exp_i;
  logic [P-1:0] norm;
  logic         unused_norm;

  always_comb begin
    lead = 0;
    for (int i = 0; i < P; i++) begin
      if (mag[i]) lead = i;
    end
    norm  = mag << (P - 1 - lead);
    exp_i = int'(exp_in) + lead - 2 * M;
    res   = '0;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (force_zero) begin
      res = {sign, {(W-1){1'b0}}};
    end else if (mag == '0) begin
      res = '0;
    end else if (exp_i > EMAX) begin
      res = {sign, SAT_FULL[W-2:0]};
      ovf = 1'b1;
    end else if (exp_i < 1) begin
      res = {sign, {(W-1){1'b0}}};
      unf = 1'b1;
    end else begin
      res = {sign, exp_i[E-1:0], norm[P-2 -: M]};
    end
  end

  // The leading one and the truncated tail are dropped by design.
  assign unused_norm = ^{norm[P-1], norm[M:0]};

endmodule

// File: rtl/float_unit_seq.sv
// Multi-cycle reduced-float mul/add/sub: IDLE -> UNPACK -> EXEC -> NORM -> DONE,
// with an LSB-first shift-add multiplier sharing the EXEC state.
module float_unit_seq
  import float_pack::*;
#(
  parameter int N_exposant = 8,
  parameter int N_mantisse = 23
) (
  input  logic             clk,
  input  logic             reset,
  float_unit_seq_if.slave  bus,
  output logic [2:0]       state_dbg
);
  localparam int E      = N_exposant;
  localparam int M      = N_mantisse;
  localparam int W      = 1 + E + M;
  localparam int P      = 2 * M + 2;
  localparam int CW     = $clog2(M + 2);
  localparam int BIAS_I = float_bias(E);
  localparam logic signed [E+1:0] BIAS = BIAS_I[E+1:0];
  localparam logic [CW-1:0]       LAST = CW'(M);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  typedef struct packed {
    logic         sign;
    logic [E-1:0] exp;
    logic [M-1:0] man;
  } float_t;

  logic [2:0]            state;
  float_t                a_r, b_r;
  op_code_e              opc;
  logic                  sign_r, eff_sub, zero_r;
  logic signed [E+1:0]   exp_r;
  logic [E-1:0]          diff;
  logic [P-1:0]          mcand, acc;
  logic [M:0]            mplier;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          res_r;
  logic                  ovf_r, unf_r;

  logic                  za, zb, is_mul, sb_eff, a_ge;
  logic [M:0]            ma, mb, aligned;
  logic [M+1:0]          sum;
  logic signed [E+1:0]   esum;
  logic [W-1:0]          n_res;
  logic                  n_ovf, n_unf;

  // Exponent field 0 is zero whatever the mantissa holds.
  assign za      = (a_r.exp == '0);
  assign zb      = (b_r.exp == '0);
  assign ma      = za ? '0 : {1'b1, a_r.man};
  assign mb      = zb ? '0 : {1'b1, b_r.man};
  assign is_mul  = (opc == OP_MUL);
  assign sb_eff  = b_r.sign ^ (opc == OP_SUB);
  assign a_ge    = {a_r.exp, a_r.man} >= {b_r.exp, b_r.man};
  assign esum    = $signed({2'b00, a_r.exp}) + $signed({2'b00, b_r.exp}) - BIAS;

  assign aligned = (32'(diff) >= 32'(M + 2)) ? '0 : (mplier >> diff);
  assign sum     = eff_sub ? ({1'b0, mcand[M:0]} - {1'b0, aligned})
                           : ({1'b0, mcand[M:0]} + {1'b0, aligned});

  float_normalize #(.N_exposant(E), .N_mantisse(M)) u_norm (
    .sign       (sign_r),
    .exp_in     (exp_r),
    .mag        (acc),
    .force_zero (zero_r),
    .res        (n_res),
    .ovf        (n_ovf),
    .unf        (n_unf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      opc     <= OP_MUL;
      sign_r  <= 1'b0;
      eff_sub <= 1'b0;
      zero_r  <= 1'b0;
      exp_r   <= '0;
      diff    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_r   <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.op_valid) begin
            a_r   <= bus.op_a;
            b_r   <= bus.op_b;
            opc   <= bus.op_code;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          cnt <= '0;
          acc <= '0;
          if (is_mul) begin
            sign_r  <= a_r.sign ^ b_r.sign;
            exp_r   <= esum;
            zero_r  <= za | zb;
            eff_sub <= 1'b0;
            diff    <= '0;
            mcand   <= {{(P-M-1){1'b0}}, ma};
            mplier  <= mb;
          end else if (a_ge) begin
            sign_r  <= a_r.sign;
            exp_r   <= {2'b00, a_r.exp};
            zero_r  <= 1'b0;
            eff_sub <= a_r.sign ^ sb_eff;
            diff    <= a_r.exp - b_r.exp;
            mcand   <= {{(P-M-1){1'b0}}, ma};
            mplier  <= mb;
          end else begin
            sign_r  <= sb_eff;
            exp_r   <= {2'b00, b_r.exp};
            zero_r  <= 1'b0;
            eff_sub <= a_r.sign ^ sb_eff;
            diff    <= b_r.exp - a_r.exp;
            mcand   <= {{(P-M-1){1'b0}}, mb};
            mplier  <= ma;
          end
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_mul) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) state <= S_NORM;
          end else begin
            // Sum lands with its unit bit at 2*M, same as the product.
            acc   <= {sum, {M{1'b0}}};
            state <= S_NORM;
          end
        end
        S_NORM: begin
          res_r <= n_res;
          ovf_r <= n_ovf;
          unf_r <= n_unf;
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready  = (state == S_IDLE);
  assign bus.res_valid = (state == S_DONE);
  assign bus.res       = res_r;
  assign bus.ovf       = ovf_r;
  assign bus.unf       = unf_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_float_unit_seq.sv
// Bench for float_unit_seq: directed vector table, random ops against an
// integer-arithmetic reference model, back-pressure and mid-op reset sequences.
module tb_float_unit_seq;
  import float_pack::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  float_unit_seq_if #(.N_exposant(8), .N_mantisse(23)) if8 ();
  float_unit_seq_if #(.N_exposant(5), .N_mantisse(10)) if5 ();
  logic [2:0] st8, st5;

  float_unit_seq #(.N_exposant(8), .N_mantisse(23)) dut8 (
    .clk(clk), .reset(reset), .bus(if8.slave), .state_dbg(st8));
  float_unit_seq #(.N_exposant(5), .N_mantisse(10)) dut5 (
    .clk(clk), .reset(reset), .bus(if5.slave), .state_dbg(st5));

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  typedef struct packed {
    logic        op_ready;
    logic        res_valid;
    logic        ovf;
    logic        unf;
    logic [31:0] res;
  } obs_t;

  typedef struct {
    int          sel;
    logic [1:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  // ---------------- helpers / driver ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{if8.op_ready, if8.res_valid, if8.ovf, if8.unf, if8.res};
    else          o = '{if5.op_ready, if5.res_valid, if5.ovf, if5.unf, 32'(if5.res)};
    return o;
  endfunction

  task automatic drive_req(input int sel, input logic [1:0] opc, input logic [31:0] a,
                           input logic [31:0] b, input logic v);
    if (sel == 0) begin
      if8.op_valid = v; if8.op_code = op_code_e'(opc); if8.op_a = a; if8.op_b = b;
    end else begin
      if5.op_valid = v; if5.op_code = op_code_e'(opc); if5.op_a = a[15:0]; if5.op_b = b[15:0];
    end
  endtask

  task automatic set_res_ready(input int sel, input logic v);
    if (sel == 0) if8.res_ready = v;
    else          if5.res_ready = v;
  endtask

  // Waits (bounded) for res_valid; lat counts edges after the acceptance edge.
  task automatic wait_result(input int sel, output int lat);
    lat = 0;
    while (!obs(sel).res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int sel, input logic [1:0] opc, input logic [31:0] a,
                        input logic [31:0] b, output obs_t o, output int lat);
    @(negedge clk);
    drive_req(sel, opc, a, b, 1'b1);
    @(posedge clk); #1;
    drive_req(sel, opc, a, b, 1'b0);
    wait_result(sel, lat);
    o = obs(sel);
    set_res_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_res_ready(sel, 1'b0);
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, unf, result}; exact integer product/sum, then truncating normalise.
  function automatic logic [33:0] ref_model(input int e, input int m, input logic [1:0] opc,
                                             input logic [31:0] a, input logic [31:0] b);
    int bias, emax, ea, eb, x, frac, tmp_i;
    logic sa, sb, sign, tmp_s;
    longint fa, fb, ma, mb, mag, small_v, tmp_l;
    bias = (1 << (e - 1)) - 1;
    emax = (1 << e) - 2;
    sa = a[e+m];
    sb = b[e+m];
    ea = int'((a >> m) & ((32'(1) << e) - 32'd1));
    eb = int'((b >> m) & ((32'(1) << e) - 32'd1));
    fa = longint'(a & ((32'(1) << m) - 32'd1));
    fb = longint'(b & ((32'(1) << m) - 32'd1));
    ma = (ea == 0) ? 0 : ((longint'(1) << m) | fa);
    mb = (eb == 0) ? 0 : ((longint'(1) << m) | fb);
    if (opc == 2'b00) begin
      sign = sa ^ sb;
      if (ma == 0 || mb == 0) return {2'b00, 32'(sign) << (e + m)};
      mag  = ma * mb;
      x    = ea + eb - bias;
      frac = 2 * m;
    end else begin
      if (opc == 2'b10) sb = ~sb;
      if (ma == 0 && mb == 0) return 34'd0;
      if (!(ea > eb || (ea == eb && fa >= fb))) begin
        tmp_l = ma; ma = mb; mb = tmp_l;
        tmp_l = fa; fa = fb; fb = tmp_l;
        tmp_i = ea; ea = eb; eb = tmp_i;
        tmp_s = sa; sa = sb; sb = tmp_s;
      end
      sign    = sa;
      small_v = (ea - eb >= m + 2) ? 0 : (mb >> (ea - eb));
      mag     = (sa != sb) ? (ma - small_v) : (ma + small_v);
      if (mag == 0) return 34'd0;
      x    = ea;
      frac = m;
    end
    while (mag >= (longint'(2) << frac)) begin mag = mag >> 1; x++; end
    while (mag <  (longint'(1) << frac)) begin mag = mag << 1; x--; end
    if (x > emax)
      return {2'b10, (32'(sign) << (e + m)) | (32'(emax) << m) | ((32'(1) << m) - 32'd1)};
    if (x < 1)
      return {2'b01, 32'(sign) << (e + m)};
    return {2'b00, (32'(sign) << (e + m)) | (32'(x) << m)
                   | 32'((mag >> (frac - m)) & ((longint'(1) << m) - 1))};
  endfunction

  // ---------------- test ----------------
  vec_t vecs [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t        o;
    int          lat;
    logic [33:0] want;
    logic [31:0] held;
    logic        seen;

    vecs[0]  = '{0, 2'b00, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 26};
    vecs[1]  = '{0, 2'b01, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[2]  = '{0, 2'b10, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 3};
    vecs[3]  = '{0, 2'b00, 32'h71800000, 32'h71800000, 32'h7F7FFFFF, 1'b1, 1'b0, 26};
    vecs[4]  = '{1, 2'b01, 32'h00003E00, 32'h00003400, 32'h00003F00, 1'b0, 1'b0, 3};
    vecs[5]  = '{0, 2'b11, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[6]  = '{0, 2'b00, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 26};
    vecs[7]  = '{0, 2'b00, 32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1, 26};
    vecs[8]  = '{0, 2'b00, 32'h80001234, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 26};
    vecs[9]  = '{0, 2'b01, 32'h00000000, 32'hC0400000, 32'hC0400000, 1'b0, 1'b0, 3};
    vecs[10] = '{0, 2'b10, 32'h00000000, 32'hC0400000, 32'h40400000, 1'b0, 1'b0, 3};
    vecs[11] = '{0, 2'b10, 32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0, 3};
    vecs[12] = '{0, 2'b01, 32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[13] = '{0, 2'b01, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0, 3};
    vecs[14] = '{1, 2'b00, 32'h00003E00, 32'h00004000, 32'h00004200, 1'b0, 1'b0, 13};
    vecs[15] = '{1, 2'b10, 32'h00003400, 32'h00003E00, 32'h0000BD00, 1'b0, 1'b0, 3};

    reset = 1'b1;
    drive_req(0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive_req(1, 2'b00, 32'h0, 32'h0, 1'b0);
    set_res_ready(0, 1'b0);
    set_res_ready(1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    o = obs(0);
    check("rst_op_ready",  32'(o.op_ready),  32'd1);
    check("rst_res_valid", 32'(o.res_valid), 32'd0);
    check("rst_res",       o.res,            32'd0);
    check("rst_ovf",       32'(o.ovf),       32'd0);
    check("rst_unf",       32'(o.unf),       32'd0);

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].sel, vecs[i].opc, vecs[i].a, vecs[i].b, o, lat);
      check($sformatf("vec%0d_res", i), o.res,          vecs[i].r);
      check($sformatf("vec%0d_ovf", i), 32'(o.ovf),     32'(vecs[i].ovf));
      check($sformatf("vec%0d_unf", i), 32'(o.unf),     32'(vecs[i].unf));
      check($sformatf("vec%0d_lat", i), 32'(lat),       32'(vecs[i].lat));
    end

    // random stimulus against the reference model
    for (int i = 0; i < 60; i++) begin
      int          sel, e, m;
      logic [1:0]  opc;
      logic [31:0] a, b, mask;
      sel  = (i < 40) ? 0 : 1;
      e    = (sel == 0) ? 8 : 5;
      m    = (sel == 0) ? 23 : 10;
      mask = (sel == 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
      opc  = 2'($urandom_range(0, 3));
      a    = $urandom & mask;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'($urandom_range(0, 255));
        default: b = $urandom & mask;
      endcase
      if ($urandom_range(0, 7) == 0) a = a & ~(((32'(1) << e) - 32'd1) << m);
      exp_q.push_back(ref_model(e, m, opc, a, b));
      run_op(sel, opc, a, b, o, lat);
      want = exp_q.pop_front();
      check($sformatf("rnd%0d_res", i),   o.res,                 want[31:0]);
      check($sformatf("rnd%0d_flags", i), 32'({o.ovf, o.unf}),   32'(want[33:32]));
      check($sformatf("rnd%0d_lat", i),   32'(lat),              (opc == 2'b00) ? 32'(m + 3) : 32'd3);
    end

    // back-pressure: result held 5 cycles while a second request waits
    @(negedge clk);
    drive_req(0, 2'b01, 32'h3F800000, 32'h3F800000, 1'b1);
    @(posedge clk); #1;
    drive_req(0, 2'b01, 32'h3F800000, 32'h40000000, 1'b1);
    wait_result(0, lat);
    check("bp_first_lat", 32'(lat), 32'd3);
    held = obs(0).res;
    check("bp_first_res", held, 32'h40000000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      o = obs(0);
      check($sformatf("bp_hold%0d_valid", k), 32'(o.res_valid), 32'd1);
      check($sformatf("bp_hold%0d_res", k),   o.res,            32'h40000000);
      check($sformatf("bp_hold%0d_ready", k), 32'(o.op_ready),  32'd0);
    end
    set_res_ready(0, 1'b1);
    @(posedge clk); #1;
    set_res_ready(0, 1'b0);
    o = obs(0);
    check("bp_after_hs_ready", 32'(o.op_ready),  32'd1);
    check("bp_after_hs_valid", 32'(o.res_valid), 32'd0);
    @(posedge clk); #1;
    drive_req(0, 2'b01, 32'h3F800000, 32'h40000000, 1'b0);
    check("bp_second_accepted", 32'(obs(0).op_ready), 32'd0);
    wait_result(0, lat);
    o = obs(0);
    check("bp_second_lat", 32'(lat), 32'd3);
    check("bp_second_res", o.res,    32'h40400000);
    set_res_ready(0, 1'b1);
    @(posedge clk); #1;
    set_res_ready(0, 1'b0);

    // reset 4 cycles into a multiply
    @(negedge clk);
    drive_req(0, 2'b00, 32'h3FC00000, 32'h40000000, 1'b1);
    @(posedge clk); #1;
    drive_req(0, 2'b00, 32'h3FC00000, 32'h40000000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_ready", 32'(obs(0).op_ready), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    o = obs(0);
    check("mid_rst_op_ready",  32'(o.op_ready),  32'd1);
    check("mid_rst_res_valid", 32'(o.res_valid), 32'd0);
    check("mid_rst_res",       o.res,            32'd0);
    check("mid_rst_ovf",       32'(o.ovf),       32'd0);
    check("mid_rst_unf",       32'(o.unf),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (obs(0).res_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
